// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Packet format shared by every router output port and input
//                buffer. A packet is 16 bits:
//                  [15:12] dx      signed hop offset in x
//                  [11:8]  dy      signed hop offset in y
//                  [7:0]   payload
//                Provides field widths/positions and field extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int PKT_W  = 16;
  localparam int DX_MSB = 15;
  localparam int DX_LSB = 12;
  localparam int DY_MSB = 11;
  localparam int DY_LSB = 8;
  localparam int OFS_W  = DX_MSB - DX_LSB + 1;

  function automatic logic signed [OFS_W-1:0] dx_of(input logic [PKT_W-1:0] pkt);
    return $signed(pkt[DX_MSB:DX_LSB]);
  endfunction

  function automatic logic signed [OFS_W-1:0] dy_of(input logic [PKT_W-1:0] pkt);
    return $signed(pkt[DY_MSB:DY_LSB]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular-buffer FIFO. Push and pop in the same
//                cycle are both honoured, including at full (the popped slot
//                frees room for the pushed word). Storage is not reset.
//  Ports       : clk, rst_n      clock, synchronous active-low reset
//                push, push_data write request / data (ignored when full
//                                 unless a pop happens in the same cycle)
//                pop             read request (ignored when empty)
//                pop_data        head-of-queue word (undefined when empty)
//                full, empty     occupancy flags (registered state only)
//                count           number of stored words
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = pop && (r_count != '0);
  // A same-cycle pop makes room, so a push at full still lands.
  assign w_do_push = push && ((r_count != c_FULL) || w_do_pop);

  // Storage: written only outside reset, never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == c_FULL);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/west_output_port.sv
`default_nettype none
// ============================================================================
//  Module      : west_output_port
//  Description : Registered west-bound output stage. Classifies each incoming
//                packet as accepted, malformed (dx >= 0) or overflow-dropped,
//                increments dx of accepted packets to record the hop, queues
//                them and presents them on the west link with valid/ready.
//  Ports       : clk, rst_n      clock, synchronous active-low reset
//                packet_in       packet from the west forwarding stage
//                valid_in        packet_in valid
//                in_ready        queue has room (informational)
//                link_packet     head-of-queue packet, dx already updated
//                link_valid      link_packet valid
//                link_ready      west neighbour accepts link_packet
//                drop_cnt        overflow drops, saturating
//                err_cnt         malformed packets, saturating
//                overflow        sticky: at least one overflow drop
//  Revision    : 1.0 - initial release
// ============================================================================
module west_output_port
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PKT_W-1:0] packet_in,
  input  logic             valid_in,
  output logic             in_ready,
  output logic [PKT_W-1:0] link_packet,
  output logic             link_valid,
  input  logic             link_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic signed [OFS_W-1:0] w_dx_in;
  logic signed [OFS_W-1:0] w_dx_next;
  logic [PKT_W-1:0]        w_enq_word;
  logic                    w_west_bound;
  logic                    w_malformed;
  logic                    w_pop;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [CW-1:0]           w_count;

  logic [CNT_W-1:0]        r_drop_cnt;
  logic [CNT_W-1:0]        r_err_cnt;
  logic                    r_overflow;

  assign w_dx_in      = dx_of(packet_in);
  // dx_in is in [-8,-1] whenever it is enqueued, so +1 cannot overflow.
  assign w_dx_next    = w_dx_in + OFS_W'(1);
  assign w_enq_word   = {w_dx_next, packet_in[DY_MSB:0]};

  assign w_west_bound = w_dx_in[OFS_W-1];
  assign w_malformed  = valid_in && !w_west_bound;
  assign w_pop        = link_valid && link_ready;
  assign w_accept     = valid_in && w_west_bound && (!w_full || w_pop);
  assign w_drop       = valid_in && w_west_bound && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_accept),
    .push_data (w_enq_word),
    .pop       (w_pop),
    .pop_data  (link_packet),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign link_valid = !w_empty;
  assign in_ready   = (w_count < c_DEPTH);

  // Saturating counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
      if (w_malformed && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign err_cnt  = r_err_cnt;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_west_output_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_west_output_port
//  Description : Self-checking bench for west_output_port. Two instances share
//                stimulus: one with 8-bit counters, one with 2-bit counters
//                for saturation. A queue-based reference model tracks the
//                expected link contents and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_west_output_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] packet_in;
  logic        valid_in;
  logic        link_ready;

  logic        in_ready,   s_in_ready;
  logic [15:0] link_packet, s_link_packet;
  logic        link_valid, s_link_valid;
  logic [7:0]  drop_cnt,   err_cnt;
  logic [1:0]  s_drop_cnt, s_err_cnt;
  logic        overflow,   s_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] m_q[$];
  int          m_drop, m_err;
  logic        m_ovf;

  always #5 clk = ~clk;

  west_output_port #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .packet_in(packet_in), .valid_in(valid_in),
    .in_ready(in_ready), .link_packet(link_packet), .link_valid(link_valid),
    .link_ready(link_ready), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
    .overflow(overflow));

  west_output_port #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .packet_in(packet_in), .valid_in(valid_in),
    .in_ready(s_in_ready), .link_packet(s_link_packet), .link_valid(s_link_valid),
    .link_ready(link_ready), .drop_cnt(s_drop_cnt), .err_cnt(s_err_cnt),
    .overflow(s_overflow));

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v;
  endfunction

  // Drive one cycle, advance the model with the rules, sample after the edge.
  task automatic cycle(input logic v, input logic [15:0] p, input logic lr, input logic rn);
    logic signed [3:0] dx;
    logic signed [3:0] dxn;
    bit pop, acc;
    valid_in = v; packet_in = p; link_ready = lr; rst_n = rn;
    dx  = $signed(p[15:12]);
    dxn = dx + 4'sd1;
    if (!rn) begin
      m_q.delete(); m_drop = 0; m_err = 0; m_ovf = 1'b0;
    end else begin
      pop = (m_q.size() != 0) && lr;
      acc = 1'b0;
      if (v) begin
        if (dx >= 0) m_err++;
        else if (m_q.size() < 4 || pop) acc = 1'b1;
        else begin m_drop++; m_ovf = 1'b1; end
      end
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back({dxn, p[11:0]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 0, 0);
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL reset_link_valid got %b want 0", link_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if ({drop_cnt, err_cnt, overflow} !== 17'd0) begin n_fail++; $display("FAIL reset_counters got drop=%0d err=%0d ovf=%b want 0", drop_cnt, err_cnt, overflow); end
  endtask

  task automatic test_single();
    cycle(1, 16'hE0A5, 1, 1);
    n_tests++; if (link_valid !== 1'b1 || link_packet !== 16'hF0A5) begin n_fail++; $display("FAIL single_out got v=%b pkt=%h want v=1 pkt=f0a5", link_valid, link_packet); end
    cycle(0, 16'h0, 1, 1);
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got v=%b want 0", link_valid); end
  endtask

  task automatic test_fill_stall();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, {8'hF0, 8'(i)}, 0, 1);
      if (i == 4) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
      end
    end
    n_tests++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL fill_drop got drop=%0d ovf=%b want 1/1", drop_cnt, overflow); end
    for (int i = 1; i <= 4; i++) begin
      n_tests++; if (link_valid !== 1'b1 || link_packet !== {8'h00, 8'(i)}) begin n_fail++; $display("FAIL fill_order[%0d] got v=%b pkt=%h want v=1 pkt=%h", i, link_valid, link_packet, {8'h00, 8'(i)}); end
      cycle(0, 16'h0, 1, 1);
    end
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got v=%b want 0", link_valid); end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 4; i++) cycle(1, {8'hF0, 8'(8'h10 + i)}, 0, 1);
    cycle(1, 16'hC0AA, 1, 1);
    n_tests++; if (in_ready !== 1'b0 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL pass_full got in_ready=%b drop=%0d want 0/1", in_ready, drop_cnt); end
    n_tests++; if (link_packet !== 16'h0011) begin n_fail++; $display("FAIL pass_head got %h want 0011", link_packet); end
    for (int i = 0; i < 3; i++) cycle(0, 16'h0, 1, 1);
    n_tests++; if (link_valid !== 1'b1 || link_packet !== 16'hD0AA) begin n_fail++; $display("FAIL pass_tail got v=%b pkt=%h want v=1 pkt=d0aa", link_valid, link_packet); end
    cycle(0, 16'h0, 1, 1);
  endtask

  task automatic test_malformed();
    cycle(1, 16'h0000, 0, 1);
    cycle(1, 16'h3000, 0, 1);
    n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL malformed_err got %0d want 2", err_cnt); end
    n_tests++; if (link_valid !== 1'b0 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL malformed_q got v=%b drop=%0d want 0/1", link_valid, drop_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1, {8'hA0, 8'(8'h40 + i)}, 0, 1);
    cycle(1, 16'h9055, 0, 0);
    n_tests++; if (link_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags got v=%b rdy=%b want 0/1", link_valid, in_ready); end
    n_tests++; if ({drop_cnt, err_cnt, overflow} !== 17'd0) begin n_fail++; $display("FAIL rstmid_counters got drop=%0d err=%0d ovf=%b want 0", drop_cnt, err_cnt, overflow); end
    cycle(1, 16'hB07E, 0, 1);
    n_tests++; if (link_valid !== 1'b1 || link_packet !== 16'hC07E) begin n_fail++; $display("FAIL rstmid_fresh got v=%b pkt=%h want v=1 pkt=c07e", link_valid, link_packet); end
    cycle(0, 16'h0, 1, 1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) cycle(1, 16'h8123, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 16'h7000, 0, 1);
    n_tests++; if (s_drop_cnt !== 2'd3 || drop_cnt !== 8'd5) begin n_fail++; $display("FAIL sat_drop got s=%0d w=%0d want 3/5", s_drop_cnt, drop_cnt); end
    n_tests++; if (s_err_cnt !== 2'd3 || err_cnt !== 8'd4) begin n_fail++; $display("FAIL sat_err got s=%0d w=%0d want 3/4", s_err_cnt, err_cnt); end
  endtask

  task automatic test_random();
    logic [15:0] p;
    for (int c = 0; c < 400; c++) begin
      p = 16'($urandom);
      if ($urandom_range(0, 3) != 0) p[15] = 1'b1;
      cycle(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) != 0));
      n_tests++; if (link_valid !== (m_q.size() != 0) || in_ready !== (m_q.size() < 4)) begin n_fail++; $display("FAIL rand_flags[%0d] got v=%b rdy=%b want size=%0d", c, link_valid, in_ready, m_q.size()); end
      if (m_q.size() != 0) begin
        n_tests++; if (link_packet !== m_q[0] || s_link_packet !== m_q[0]) begin n_fail++; $display("FAIL rand_pkt[%0d] got %h/%h want %h", c, link_packet, s_link_packet, m_q[0]); end
      end
      n_tests++; if (drop_cnt !== 8'(sat(m_drop, 255)) || err_cnt !== 8'(sat(m_err, 255)) || overflow !== m_ovf) begin n_fail++; $display("FAIL rand_cnt[%0d] got drop=%0d err=%0d ovf=%b want %0d/%0d/%b", c, drop_cnt, err_cnt, overflow, sat(m_drop, 255), sat(m_err, 255), m_ovf); end
      n_tests++; if (s_drop_cnt !== 2'(sat(m_drop, 3)) || s_err_cnt !== 2'(sat(m_err, 3)) || s_overflow !== m_ovf) begin n_fail++; $display("FAIL rand_satcnt[%0d] got drop=%0d err=%0d ovf=%b want %0d/%0d/%b", c, s_drop_cnt, s_err_cnt, s_overflow, sat(m_drop, 3), sat(m_err, 3), m_ovf); end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; packet_in = '0; link_ready = 1'b0;
    m_drop = 0; m_err = 0; m_ovf = 1'b0;
    test_reset();
    test_single();
    test_fill_stall();
    test_pass_through();
    test_malformed();
    test_reset_mid();
    cycle(0, 16'h0, 0, 0);
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
